// File: rtl/burst_downsizer_pkg.sv
// burst_downsizer_pkg
// Shared types and constants for the burst downsizer.
//   in_state_t : input-side framing state (SYNC: hunting for SOF, LOAD: inside a frame)
//   TUSER_SOF / TUSER_EOL : bit positions of the markers in m_axis_tuser
//   params_ok() : parameter sanity check used at elaboration time
package burst_downsizer_pkg;

  typedef enum logic {SYNC, LOAD} in_state_t;

  localparam int TUSER_SOF = 0;
  localparam int TUSER_EOL = 1;

  function automatic bit params_ok(int in_pixels, int out_pixels, int in_rows, int in_cols);
    return (out_pixels > 0) && (in_pixels >= out_pixels) &&
           (in_pixels % out_pixels == 0) && (in_rows >= 2) && (in_cols >= 2) &&
           (in_cols % in_pixels == 0);
  endfunction

endpackage

// File: rtl/burst_downsizer_slot.sv
// burst_slot_buffer
// Two-entry ping-pong register holding whole input bursts.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, wr_data   : write one burst into the free slot
//   pop             : release the slot currently being read
//   flush           : drop everything; a push in the same cycle becomes the only entry
//   rd_data         : contents of the slot being read
//   occupancy       : number of filled slots, 0..2
module burst_slot_buffer #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else if (flush) begin
      // The burst arriving with the flush lands in slot 0 and is read next.
      rd_ptr    <= 1'b0;
      wr_ptr    <= push;
      occupancy <= {1'b0, push};
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      occupancy <= occupancy + 2'd1;
      else if (pop && !push) occupancy <= occupancy - 2'd1;
    end
  end

  // Data storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      if (flush) slot[0]      <= wr_data;
      else       slot[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = slot[rd_ptr];

endmodule

// File: rtl/burst_downsizer.sv
// burst_downsizer
// Splits IN_PIXELS-wide camera bursts into OUT_PIXELS-wide output beats at up to
// one beat per clock, tracks frame position and emits SOF/EOL/tlast markers.
// Ports:
//   clk, srst                    : clock, synchronous active-high reset
//   s_axis_*                     : wide input stream, tuser[0] = start of frame
//   m_axis_*                     : narrow output stream, tuser = {EOL, SOF}, tlast = end of frame
//   cnt_col, cnt_row             : position of the current output beat's pixel 0
//   frame_err                    : sticky, set by an SOF arriving inside a frame
// Build option:
//   BURST_DOWNSIZER_RESYNC_EN    : a mid-frame SOF flushes buffered data and restarts
//                                  the frame; otherwise the SOF bit is ignored.
module burst_downsizer
  import burst_downsizer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int IN_PIXELS       = 10,
  parameter int OUT_PIXELS      = 1,
  parameter int USER_WIDTH      = 2,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                                  clk,
  input  logic                                  srst,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH*IN_PIXELS-1:0]  s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                 s_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*OUT_PIXELS-1:0] m_axis_tdata,
  output logic [1:0]                            m_axis_tuser,
  output logic                                  m_axis_tlast,
  output logic [$clog2(IN_COLS)-1:0]            cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]            cnt_row,
  output logic                                  frame_err
);

  localparam int RATIO       = IN_PIXELS / OUT_PIXELS;
  localparam int FRAME_BEATS = IN_ROWS * IN_COLS / IN_PIXELS;
  localparam int IN_W        = PIXEL_BIT_WIDTH * IN_PIXELS;
  localparam int OUT_W       = PIXEL_BIT_WIDTH * OUT_PIXELS;
  localparam int SUB_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W      = $clog2(FRAME_BEATS + 1);
  localparam int COL_W       = $clog2(IN_COLS);
  localparam int ROW_W       = $clog2(IN_ROWS);

  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] FRAME_LAST = BEAT_W'(FRAME_BEATS);
  localparam logic [COL_W-1:0]  COL_STEP   = COL_W'(OUT_PIXELS);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IN_COLS - OUT_PIXELS);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IN_ROWS - 1);

  if (!params_ok(IN_PIXELS, OUT_PIXELS, IN_ROWS, IN_COLS)) begin : g_param_check
    $error("burst_downsizer: illegal IN_PIXELS/OUT_PIXELS/IN_ROWS/IN_COLS combination");
  end

  in_state_t         state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              in_hs, sof_in, mid_sof;
  logic              push, pop, flush, err_set;
  logic [1:0]        occupancy;
  logic [IN_W-1:0]   rd_data;

  logic [SUB_W-1:0]  sub_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              err_q;
  logic              out_hs, sof_mark, eol_mark, last_mark;

  // Only the SOF bit of the input user field carries meaning.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign s_axis_tready = (occupancy != 2'd2);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign sof_in        = s_axis_tuser[TUSER_SOF];
  assign mid_sof       = sof_in && (beat_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= SYNC;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    push       = 1'b0;
    flush      = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      SYNC: begin
        if (in_hs && sof_in) begin
          push       = 1'b1;
          beat_cnt_d = BEAT_W'(1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (in_hs) begin
          push       = 1'b1;
          err_set    = mid_sof;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
`ifdef BURST_DOWNSIZER_RESYNC_EN
          if (mid_sof) begin
            flush      = 1'b1;
            beat_cnt_d = BEAT_W'(1);
          end
`endif
          if (beat_cnt_d == FRAME_LAST) begin
            state_d    = SYNC;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  burst_slot_buffer #(.WIDTH(IN_W)) u_slots (
    .clk       (clk),
    .reset     (srst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_data   (s_axis_tdata),
    .rd_data   (rd_data),
    .occupancy (occupancy)
  );

  assign m_axis_tvalid = (occupancy != 2'd0);
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign pop           = out_hs && (sub_q == SUB_LAST);
  assign m_axis_tdata  = rd_data[sub_q*OUT_W +: OUT_W];

  assign sof_mark  = (col_q == '0) && (row_q == '0);
  assign eol_mark  = (col_q == COL_LAST);
  assign last_mark = eol_mark && (row_q == ROW_LAST);

  // Markers are qualified with valid so an idle output presents all-zero sideband.
  always_comb begin
    m_axis_tuser            = '0;
    m_axis_tuser[TUSER_SOF] = m_axis_tvalid && sof_mark;
    m_axis_tuser[TUSER_EOL] = m_axis_tvalid && eol_mark;
  end
  assign m_axis_tlast = m_axis_tvalid && last_mark;

  always_ff @(posedge clk) begin
    if (srst) begin
      sub_q <= '0;
      col_q <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (flush) begin
        sub_q <= '0;
        col_q <= '0;
        row_q <= '0;
      end else if (out_hs) begin
        sub_q <= (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        if (last_mark) begin
          col_q <= '0;
          row_q <= '0;
        end else if (eol_mark) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_STEP;
        end
      end
    end
  end

  assign cnt_col   = col_q;
  assign cnt_row   = row_q;
  assign frame_err = err_q;

endmodule

// File: doc/burst_downsizer.md
Name: burst_downsizer

Overview:
Parameterised successor to the single-pixel sequentializer. Converts wide camera bursts of IN_PIXELS pixels into narrower output beats of OUT_PIXELS pixels. A 2-slot ping-pong buffer lets the next burst load while the current one streams, so output sustains 1 beat/clk. Tracks frame position, emits SOF/EOL/tlast markers, and resynchronises on start-of-frame. Sits between the CXP frame-grabber stream and the per-pixel processing chain.

Parameters:
- PIXEL_BIT_WIDTH, 10, bits per pixel.
- IN_PIXELS, 10, pixels per input beat.
- OUT_PIXELS, 1, pixels per output beat; must divide IN_PIXELS; RATIO = IN_PIXELS/OUT_PIXELS.
- USER_WIDTH, 2, input tuser width; only bit 0 (SOF) is used.
- IN_ROWS, 20, rows per frame; ≥2.
- IN_COLS, 20, columns per frame; ≥2; multiple of IN_PIXELS.

Ports:
- clk  in  1  single clock.
- srst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  PIXEL_BIT_WIDTH*IN_PIXELS  pixel 0 in the LSBs.
- s_axis_tuser  in  USER_WIDTH  bit0 = SOF.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  PIXEL_BIT_WIDTH*OUT_PIXELS  lowest-index pixel in the LSBs.
- m_axis_tuser  out  2  bit0 = SOF (first beat of frame), bit1 = EOL (last beat of row).
- m_axis_tlast  out  1  last beat of frame.
- cnt_col  out  $clog2(IN_COLS)  column of the current output beat's pixel 0.
- cnt_row  out  $clog2(IN_ROWS)  row of the current output beat.
- frame_err  out  1  sticky flag; cleared only by srst.

Behaviour:
- Reset: buffer empty; input FSM=SYNC; all counters=0; m_axis_tvalid=0; m_axis_tuser=0; m_axis_tlast=0; frame_err=0. srst mid-frame discards buffered data immediately.
- s_axis_tready = (occupancy<2) in both input states. Occupancy is 0..2. A push and pop in the same cycle leaves occupancy unchanged.
- Input FSM:
  - SYNC: accepted beats with tuser[0]=0 are discarded. An accepted beat with tuser[0]=1 is pushed; go to LOAD with in_beat_cnt=1.
  - LOAD: every accepted beat is pushed. When in_beat_cnt reaches IN_ROWS*IN_COLS/IN_PIXELS, return to SYNC.
- Output:
  - m_axis_tvalid = occupancy>0.
  - tdata = read slot pixels [sub*OUT_PIXELS +: OUT_PIXELS].
  - sub advances on each m handshake; at sub=RATIO-1 the slot pops and sub returns to 0.
- Latency: a beat accepted into an empty buffer at cycle N gives m_axis_tvalid=1 at N+1. There are no bubbles between slots.
- Counters:
  - cnt_col advances by OUT_PIXELS per m handshake and wraps 0 at IN_COLS; the wrap advances cnt_row.
  - After the beat with tlast, both counters return to 0.
- Markers:
  - SOF = (cnt_col==0 && cnt_row==0).
  - EOL = (cnt_col==IN_COLS-OUT_PIXELS).
  - tlast = EOL && cnt_row==IN_ROWS-1.
- Stall: while m_axis_tready=0, tdata, tuser, tlast and counters hold stable.
- Mid-frame SOF (accepted beat in LOAD with tuser[0]=1 and in_beat_cnt≠0): handling depends on the macro below; frame_err is set in either case.

Optional Feature:
BURST_DOWNSIZER_RESYNC_EN
- Defined:
  - A mid-frame SOF flushes the buffer and keeps only the new beat (occupancy=1).
  - sub, cnt_col, cnt_row and in_beat_cnt restart with in_beat_cnt=1.
  - The truncated frame ends without tlast.
- Undefined: the SOF bit is ignored and the beat is treated as ordinary data; only frame_err is set.

Decomposition:
- Package burst_downsizer_pkg:
  - in_state_t enum {SYNC, LOAD}.
  - Constants TUSER_SOF=0, TUSER_EOL=1.
  - Function checking divisibility of the parameters, used by elaboration asserts.
- Sub-module burst_slot_buffer: 2-entry ping-pong register. Contains wr_ptr, rd_ptr, occupancy, and a flush input.

Test Plan:
- Default params; continuous frame of 40 beats with ramp pixels 0..399, SOF on beat 0, m_axis_tready=1 → 400 output beats with tdata=0..399 and no gaps after the first. SOF on beat 0; EOL on beats 19, 39, …; tlast only on beat 399; counters back to 0.
- OUT_PIXELS=2 → 200 beats; beat k carries pixels {2k+1, 2k}; EOL every 10 beats.
- 3 beats without SOF before the frame → all 3 dropped with tready=1; first output pixel is 0.
- m_axis_tready toggles in a 1-of-3 pattern → s_axis_tready deasserts when occupancy=2; no pixel is lost or repeated; outputs are stable during stalls.
- SOF injected on beat 15 of a frame:
  - RESYNC_EN defined: buffer flushed; next output has SOF=1, cnt_col=0, cnt_row=0; frame_err=1.
  - RESYNC_EN undefined: stream continues; the frame completes with tlast at output 399; frame_err=1.
- srst asserted mid-frame at output 123 → next cycle tvalid=0, counters=0, FSM=SYNC; a following clean frame is output correctly.
